ctrl_sequencer: RTL and testbench

//   Generates the start/valid/stop control sequence for one datapath run of TOTAL beats.

---
 rtl/ctrl_sequencer.sv | 110 +++++++++++
 tb/tb_ctrl_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - start/valid/stop control sequencer with DELAY-aligned copy and done.
// Optional abort input enabled by CTRL_SEQ_ABORT_EN.
module ctrl_sequencer #(
    parameter int CNTW  = 16,
    parameter int DELAY = 3
) (
    input  logic            clk,
    input  logic            xrst,
    input  logic            req,
    input  logic [CNTW-1:0] total,
    input  logic            stall,
`ifdef CTRL_SEQ_ABORT_EN
    input  logic            abort,
`endif
    output logic            out_start,
    output logic            out_valid,
    output logic            out_stop,
    output logic            d_start,
    output logic            d_valid,
    output logic            d_stop,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {IDLE, START, RUN, STOP, DRAIN} state_t;

    state_t          state, state_n;
    logic [CNTW-1:0] count, count_n;
    logic [CNTW-1:0] total_r, total_n;
    logic            abort_i;

`ifdef CTRL_SEQ_ABORT_EN
    assign abort_i = abort && (state == START || state == RUN);
`else
    assign abort_i = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!xrst) begin
            state   <= IDLE;
            count   <= '0;
            total_r <= '0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            total_r <= total_n;
        end
    end

    // Comparing against total_r-1 lets the maximum total run without count wrapping.
    always_comb begin
        state_n = state;
        count_n = count;
        total_n = total_r;
        case (state)
            IDLE: begin
                if (req) begin
                    total_n = total;
                    count_n = '0;
                    state_n = START;
                end
            end
            START: begin
                if (abort_i || total_r == '0)
                    state_n = STOP;
                else
                    state_n = RUN;
            end
            RUN: begin
                if (abort_i) begin
                    state_n = STOP;
                end else if (!stall) begin
                    count_n = count + 1'b1;
                    if (count == total_r - 1'b1)
                        state_n = STOP;
                end
            end
            STOP:    state_n = (DELAY > 0) ? DRAIN : IDLE;
            DRAIN:   if (d_stop) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign out_start = (state == START);
    assign out_valid = (state == RUN) && !stall && !abort_i;
    assign out_stop  = (state == STOP);
    assign busy      = (state != IDLE);
    assign done      = (DELAY == 0) ? out_stop : (state == DRAIN && d_stop);

    generate
        if (DELAY == 0) begin : g_nodelay
            assign d_start = out_start;
            assign d_valid = out_valid;
            assign d_stop  = out_stop;
        end else begin : g_delay
            logic [2:0] dl [DELAY];
            // Shifts every cycle regardless of stall so d_* are pure time shifts of out_*.
            always_ff @(posedge clk) begin
                if (!xrst) begin
                    for (int i = 0; i < DELAY; i++) dl[i] <= 3'b000;
                end else begin
                    dl[0] <= {out_start, out_valid, out_stop};
                    for (int i = 1; i < DELAY; i++) dl[i] <= dl[i-1];
                end
            end
            assign {d_start, d_valid, d_stop} = dl[DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb/tb_ctrl_sequencer.sv - directed self-checking bench for ctrl_sequencer (DELAY=3 and DELAY=0).
module tb_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        xrst, req, stall, abort;
    logic [15:0] total;
    logic        out_start, out_valid, out_stop, d_start, d_valid, d_stop, busy, done;
    logic        o0_start, o0_valid, o0_stop, e0_start, e0_valid, e0_stop, busy0, done0;

    int checks = 0;
    int failures = 0;

    logic [31:0] v_st, v_vl, v_sp, v_ds, v_dv, v_dsp, v_dn, v_by, v0_sp, v0_dsp, v0_dn, v0_by;

    always #5 clk = ~clk;

    ctrl_sequencer #(.CNTW(16), .DELAY(3)) dut (
        .clk(clk), .xrst(xrst), .req(req), .total(total), .stall(stall),
`ifdef CTRL_SEQ_ABORT_EN
        .abort(abort),
`endif
        .out_start(out_start), .out_valid(out_valid), .out_stop(out_stop),
        .d_start(d_start), .d_valid(d_valid), .d_stop(d_stop),
        .busy(busy), .done(done)
    );

    ctrl_sequencer #(.CNTW(16), .DELAY(0)) dut0 (
        .clk(clk), .xrst(xrst), .req(req), .total(total), .stall(stall),
`ifdef CTRL_SEQ_ABORT_EN
        .abort(abort),
`endif
        .out_start(o0_start), .out_valid(o0_valid), .out_stop(o0_stop),
        .d_start(e0_start), .d_valid(e0_valid), .d_stop(e0_stop),
        .busy(busy0), .done(done0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs just after the edge, sample outputs at the falling edge.
    task automatic cyc(input int c, input logic r, input logic [15:0] t, input logic s, input logic a);
        @(posedge clk);
        #1;
        req = r; total = t; stall = s; abort = a;
        @(negedge clk);
        v_st[c] = out_start; v_vl[c] = out_valid; v_sp[c] = out_stop;
        v_ds[c] = d_start;   v_dv[c] = d_valid;   v_dsp[c] = d_stop;
        v_dn[c] = done;      v_by[c] = busy;
        v0_sp[c] = o0_stop;  v0_dsp[c] = e0_stop; v0_dn[c] = done0; v0_by[c] = busy0;
    endtask

    task automatic clear_vecs();
        v_st = '0; v_vl = '0; v_sp = '0; v_ds = '0; v_dv = '0; v_dsp = '0;
        v_dn = '0; v_by = '0; v0_sp = '0; v0_dsp = '0; v0_dn = '0; v0_by = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        xrst = 1'b0; req = 1'b1; total = 16'd5; stall = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        xrst = 1'b1; req = 1'b0;
    endtask

    initial begin
        xrst = 1'b0; req = 1'b0; total = '0; stall = 1'b0; abort = 1'b0;
        clear_vecs();

        // 1: reset held 2 cycles with req high; outputs all zero, req ignored
        do_reset();
        @(negedge clk);
        chk("reset_outs", {24'd0, out_start, out_valid, out_stop, d_start, d_valid, d_stop, busy, done}, 32'd0);
        chk("reset_outs0", {28'd0, o0_stop, e0_stop, busy0, done0}, 32'd0);
        clear_vecs();
        for (int c = 0; c < 4; c++) cyc(c, 1'b0, 16'd0, 1'b0, 1'b0);
        chk("reset_req_ignored", v_by, 32'd0);

        // 2: total=4, no stall
        do_reset();
        clear_vecs();
        for (int c = 0; c < 16; c++) cyc(c, c == 0, 16'd4, 1'b0, 1'b0);
        chk("t2_start", v_st, 32'h2);
        chk("t2_valid", v_vl, 32'h3C);
        chk("t2_stop", v_sp, 32'h40);
        chk("t2_d_start", v_ds, 32'h10);
        chk("t2_d_valid", v_dv, 32'h1E0);
        chk("t2_d_stop", v_dsp, 32'h200);
        chk("t2_done", v_dn, 32'h200);
        chk("t2_busy", v_by, 32'h3FE);

        // 3: total=4, stall in cycles 3-4
        do_reset();
        clear_vecs();
        for (int c = 0; c < 16; c++) cyc(c, c == 0, 16'd4, (c == 3 || c == 4), 1'b0);
        chk("t3_valid", v_vl, 32'hE4);
        chk("t3_stop", v_sp, 32'h100);
        chk("t3_d_valid", v_dv, 32'h720);
        chk("t3_done", v_dn, 32'h800);
        chk("t3_busy", v_by, 32'hFFE);

        // 4: total=0, DELAY=3 and DELAY=0
        do_reset();
        clear_vecs();
        for (int c = 0; c < 12; c++) cyc(c, c == 0, 16'd0, 1'b0, 1'b0);
        chk("t4_start", v_st, 32'h2);
        chk("t4_valid", v_vl, 32'h0);
        chk("t4_stop", v_sp, 32'h4);
        chk("t4_done", v_dn, 32'h20);
        chk("t4_busy", v_by, 32'h3E);
        chk("t4_d0_stop", v0_dsp, 32'h4);
        chk("t4_d0_done", v0_dn, 32'h4);
        chk("t4_d0_busy", v0_by, 32'h6);

        // total=1 boundary
        do_reset();
        clear_vecs();
        for (int c = 0; c < 10; c++) cyc(c, c == 0, 16'd1, 1'b0, 1'b0);
        chk("t1b_valid", v_vl, 32'h4);
        chk("t1b_stop", v_sp, 32'h8);
        chk("t1b_done", v_dn, 32'h40);
        chk("t1b_d0_done", v0_dn, 32'h8);

        // 5a: req pulsed mid-run and total changed after acceptance
        do_reset();
        clear_vecs();
        for (int c = 0; c < 16; c++) cyc(c, (c == 0 || c == 3), (c == 0) ? 16'd4 : 16'd9, 1'b0, 1'b0);
        chk("t5_start", v_st, 32'h2);
        chk("t5_valid", v_vl, 32'h3C);
        chk("t5_stop", v_sp, 32'h40);
        chk("t5_done", v_dn, 32'h200);

        // 5b: req held high, back-to-back runs of total=2
        do_reset();
        clear_vecs();
        for (int c = 0; c < 16; c++) cyc(c, 1'b1, 16'd2, 1'b0, 1'b0);
        chk("t5b_start", v_st, 32'h202);
        chk("t5b_valid", v_vl, 32'hC0C);
        chk("t5b_done", v_dn, 32'h8080);
        chk("t5b_busy", v_by, 32'hFEFE);

`ifdef CTRL_SEQ_ABORT_EN
        // 6: total=10, abort in cycle 4
        do_reset();
        clear_vecs();
        for (int c = 0; c < 12; c++) cyc(c, c == 0, 16'd10, 1'b0, c == 4);
        chk("t6_valid", v_vl, 32'hC);
        chk("t6_stop", v_sp, 32'h20);
        chk("t6_done", v_dn, 32'h100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
